// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive state machines:
// FSM state encoding, parity-mode encodings and the default oversample rate.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int OVERSAMPLE_DEF = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // 2'b11 is treated the same as PAR_NONE
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   function automatic logic par_enabled(input logic [1:0] par);
      return (par == PAR_EVEN) || (par == PAR_ODD);
   endfunction

endpackage

// File: rtl/rx_sync.sv
// ---------------------------------------------------------------------------
// rx_sync
// Multi-flop synchronizer for the asynchronous serial input. All flops reset
// to 1 so the line reads as idle while reset is asserted.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   d_i  - asynchronous input
//   q_o  - synchronized output (SYNC_STAGES clocks of latency)
// ---------------------------------------------------------------------------
module rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/receiver_fsm.sv
// ---------------------------------------------------------------------------
// receiver_fsm
// UART receiver. Oversamples the synchronized serial line with bd_tick,
// samples every bit at mid-bit, checks parity and stop bits and emits one
// rx_done pulse per completed frame.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-low reset
//   bd_tick    - one-clk oversample enable, OVERSAMPLE per bit
//   D_num      - 0: 7 data bits, 1: 8 data bits
//   S_num      - 0: 1 stop bit, 1: 2 stop bits
//   Par        - 00/11 none, 01 even, 10 odd
//   rx         - asynchronous serial line, idle high, LSB first
//   d_out      - last received byte (bit 7 is 0 in 7-bit mode)
//   rx_done    - one-clk pulse when a frame completes
//   parity_err - parity mismatch in the last frame
//   frame_err  - a stop bit sampled low in the last frame
//   is_active  - FSM not in IDLE
// ---------------------------------------------------------------------------
module receiver_fsm
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bd_tick,
   input  logic       D_num,
   input  logic       S_num,
   input  logic [1:0] Par,
   input  logic       rx,
   output logic [7:0] d_out,
   output logic       rx_done,
   output logic       parity_err,
   output logic       frame_err,
   output logic       is_active
);

   localparam int            CW   = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   logic          rx_s;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          dnum_q, dnum_d;
   logic          snum_q, snum_d;
   logic [1:0]    par_q, par_d;
   logic          perr_int_q, perr_int_d;
   logic          ferr_int_q, ferr_int_d;
   logic [7:0]    d_out_q, d_out_d;
   logic          rx_done_q, rx_done_d;
   logic          perr_q, perr_d;
   logic          ferr_q, ferr_d;

   logic [7:0]    data8;
   logic          data_xor;

   rx_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_rx_sync (
      .clk (clk),
      .rst (rst),
      .d_i (rx),
      .q_o (rx_s)
   );

   // Bits are shifted in at the MSB, so a 7-bit frame ends up in [7:1] and
   // bit 0 still holds a stale bit; right-align and zero the top bit.
   assign data8    = dnum_q ? sh_q : {1'b0, sh_q[7:1]};
   assign data_xor = ^data8;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      sh_d       = sh_q;
      dnum_d     = dnum_q;
      snum_d     = snum_q;
      par_d      = par_q;
      perr_int_d = perr_int_q;
      ferr_int_d = ferr_int_q;
      d_out_d    = d_out_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      rx_done_d  = 1'b0;

      if (bd_tick) begin
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  // Frame configuration is frozen here for the whole frame
                  state_d    = START;
                  cnt_d      = '0;
                  dnum_d     = D_num;
                  snum_d     = S_num;
                  par_d      = Par;
                  perr_int_d = 1'b0;
                  ferr_int_d = 1'b0;
               end
            end

            START: begin
               if (cnt_q == HALF) begin
                  if (rx_s) begin
                     state_d = IDLE;   // glitch, not a real start bit
                  end else begin
                     state_d = DATA;
                     cnt_d   = '0;
                     bit_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            DATA: begin
               if (cnt_q == LAST) begin
                  sh_d  = {rx_s, sh_q[7:1]};
                  cnt_d = '0;
                  if (bit_q == (dnum_q ? 3'd7 : 3'd6)) begin
                     bit_d   = '0;
                     state_d = par_enabled(par_q) ? PARITY : STOP;
                  end else begin
                     bit_d = bit_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            PARITY: begin
               if (cnt_q == LAST) begin
                  cnt_d      = '0;
                  bit_d      = '0;
                  state_d    = STOP;
                  perr_int_d = (par_q == PAR_EVEN) ? (data_xor ^ rx_s)
                                                   : ~(data_xor ^ rx_s);
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            STOP: begin
               if (cnt_q == LAST) begin
                  cnt_d = '0;
                  // bit_q marks whether the first of two stop bits is done
                  if (snum_q && (bit_q == 3'd0)) begin
                     bit_d      = 3'd1;
                     ferr_int_d = ferr_int_q | ~rx_s;
                  end else begin
                     // Leave at mid-stop so a back-to-back start is caught
                     state_d   = IDLE;
                     bit_d     = '0;
                     d_out_d   = data8;
                     perr_d    = perr_int_q;
                     ferr_d    = ferr_int_q | ~rx_s;
                     rx_done_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         sh_q       <= '0;
         dnum_q     <= 1'b0;
         snum_q     <= 1'b0;
         par_q      <= PAR_NONE;
         perr_int_q <= 1'b0;
         ferr_int_q <= 1'b0;
         d_out_q    <= '0;
         rx_done_q  <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         sh_q       <= sh_d;
         dnum_q     <= dnum_d;
         snum_q     <= snum_d;
         par_q      <= par_d;
         perr_int_q <= perr_int_d;
         ferr_int_q <= ferr_int_d;
         d_out_q    <= d_out_d;
         rx_done_q  <= rx_done_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
      end
   end

   assign d_out      = d_out_q;
   assign rx_done    = rx_done_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign is_active  = (state_q != IDLE);

endmodule

// File: tb/tb_receiver_fsm.sv
// ---------------------------------------------------------------------------
// tb_receiver_fsm
// Bench for receiver_fsm: a behavioural serializer drives the rx line one
// bit period (16 ticks) at a time; received frames are collected by a
// monitor and compared against table constants or a frame-level model.
// ---------------------------------------------------------------------------
module tb_receiver_fsm;

   localparam int          OS   = 16;
   localparam int          TDIV = 4;     // clocks per bd_tick
   localparam logic [1:0]  P_NONE = 2'b00;
   localparam logic [1:0]  P_EVEN = 2'b01;
   localparam logic [1:0]  P_ODD  = 2'b10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       bd_tick = 1'b0;
   logic       D_num = 1'b1;
   logic       S_num = 1'b0;
   logic [1:0] Par = 2'b00;
   logic       rx = 1'b1;
   logic [7:0] d_out;
   logic       rx_done;
   logic       parity_err;
   logic       frame_err;
   logic       is_active;

   int errors = 0;
   int checks = 0;

   receiver_fsm #(
      .OVERSAMPLE (OS),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bd_tick    (bd_tick),
      .D_num      (D_num),
      .S_num      (S_num),
      .Par        (Par),
      .rx         (rx),
      .d_out      (d_out),
      .rx_done    (rx_done),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .is_active  (is_active)
   );

   always #5 clk = ~clk;

   int div = 0;
   always @(negedge clk) begin
      div     = (div == TDIV - 1) ? 0 : div + 1;
      bd_tick = (div == 0);
   end

   // Monitor: collect every completed frame as {ferr, perr, d}
   logic [9:0] rxq[$];
   logic       prev_done = 1'b0;
   int         dbl_pulse = 0;
   int         active_at_done = 0;
   always @(negedge clk) begin
      if (rx_done === 1'b1) begin
         rxq.push_back({frame_err, parity_err, d_out});
         if (is_active !== 1'b0) active_at_done++;
         if (prev_done === 1'b1) dbl_pulse++;
      end
      prev_done = rx_done;
   end

   typedef struct {
      logic [7:0] data;
      logic       dn;
      logic       sn;
      logic [1:0] par;
      logic       inv;
      logic       stop_low;
      logic [7:0] exp_d;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_tick();
      do @(posedge clk); while (bd_tick !== 1'b1);
      @(negedge clk);
   endtask

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) wait_tick();
   endtask

   // Serializer: start, data LSB first, optional parity, 1 or 2 stops
   task automatic send_frame(input logic [7:0] data, input logic dn, input logic sn,
                             input logic [1:0] p, input logic inv,
                             input logic stop_low, input logic scramble);
      int   n;
      logic pb;
      logic [7:0] bits;
      D_num = dn;
      S_num = sn;
      Par   = p;
      n     = dn ? 8 : 7;
      bits  = dn ? data : {1'b0, data[6:0]};
      hold(1'b0, OS);
      if (scramble) begin
         D_num = 1'($urandom);
         S_num = 1'($urandom);
         Par   = 2'($urandom);
      end
      for (int i = 0; i < n; i++) hold(data[i], OS);
      if (p == P_EVEN || p == P_ODD) begin
         pb = (^bits) ^ (p == P_ODD) ^ inv;
         hold(pb, OS);
      end
      hold(~stop_low, OS);
      if (sn) hold(~stop_low, OS);
   endtask

   // Frame-level reference: what the receiver should report for a frame
   task automatic model(input logic [7:0] data, input logic dn, input logic [1:0] p,
                        input logic inv, input logic stop_low,
                        output logic [7:0] ed, output logic ep, output logic ef);
      logic x, pb;
      ed = dn ? data : {1'b0, data[6:0]};
      x  = ^ed;
      pb = x ^ (p == P_ODD) ^ inv;       // bit the line carried
      if (p == P_EVEN)      ep = x ^ pb;
      else if (p == P_ODD)  ep = ~(x ^ pb);
      else                  ep = 1'b0;
      ef = stop_low;
   endtask

   task automatic run_frame(input vec_t v, input string nm, input logic scramble);
      logic [9:0] rec;
      rxq.delete();
      send_frame(v.data, v.dn, v.sn, v.par, v.inv, v.stop_low, scramble);
      hold(1'b1, OS);
      chk({nm, " done count"}, rxq.size(), 1);
      rec = (rxq.size() > 0) ? rxq.pop_front() : 10'h3FF;
      chk({nm, " d_out"}, rec[7:0], v.exp_d);
      chk({nm, " parity_err"}, rec[8], v.exp_perr);
      chk({nm, " frame_err"}, rec[9], v.exp_ferr);
   endtask

   initial begin
      vec_t       v;
      logic [9:0] rec;
      logic [7:0] d_before;
      int         waited;

      tbl[0] = '{8'hDC, 1'b1, 1'b0, P_NONE, 1'b0, 1'b0, 8'hDC, 1'b0, 1'b0};
      tbl[1] = '{8'hDC, 1'b1, 1'b1, P_ODD,  1'b0, 1'b0, 8'hDC, 1'b0, 1'b0};
      tbl[2] = '{8'hDC, 1'b1, 1'b1, P_ODD,  1'b1, 1'b0, 8'hDC, 1'b1, 1'b0};
      tbl[3] = '{8'h55, 1'b0, 1'b0, P_EVEN, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0};
      tbl[4] = '{8'hDC, 1'b1, 1'b0, P_NONE, 1'b0, 1'b1, 8'hDC, 1'b0, 1'b1};
      tbl[5] = '{8'hA5, 1'b1, 1'b0, P_NONE, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
      tbl[6] = '{8'hFF, 1'b0, 1'b0, P_ODD,  1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
      tbl[7] = '{8'hAA, 1'b0, 1'b1, P_EVEN, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b1};
      tbl[8] = '{8'h3C, 1'b1, 1'b1, 2'b11,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};

      // Reset state
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset d_out", d_out, 8'h00);
      chk("reset rx_done", rx_done, 1'b0);
      chk("reset parity_err", parity_err, 1'b0);
      chk("reset frame_err", frame_err, 1'b0);
      chk("reset is_active", is_active, 1'b0);
      rst = 1'b1;
      hold(1'b1, 4);

      // Directed table
      for (int i = 0; i < 9; i++) run_frame(tbl[i], $sformatf("tbl%0d", i), 1'b0);

      // Back-to-back frames with no idle gap
      rxq.delete();
      send_frame(8'hDC, 1'b1, 1'b0, P_NONE, 1'b0, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b1, 1'b0, P_NONE, 1'b0, 1'b0, 1'b0);
      hold(1'b1, OS);
      chk("b2b count", rxq.size(), 2);
      rec = (rxq.size() > 0) ? rxq.pop_front() : 10'h3FF;
      chk("b2b first", rec, {2'b00, 8'hDC});
      rec = (rxq.size() > 0) ? rxq.pop_front() : 10'h3FF;
      chk("b2b second", rec, {2'b00, 8'hA5});

      // Random frames; configuration inputs scrambled mid-frame
      for (int i = 0; i < 25; i++) begin
         v.data     = 8'($urandom);
         v.dn       = 1'($urandom);
         v.sn       = 1'($urandom);
         v.par      = 2'($urandom);
         v.inv      = 1'($urandom);
         v.stop_low = ($urandom_range(0, 5) == 0);
         model(v.data, v.dn, v.par, v.inv, v.stop_low, v.exp_d, v.exp_perr, v.exp_ferr);
         run_frame(v, $sformatf("rand%0d", i), 1'b1);
      end

      // False start: low for 4 ticks, START aborts at its mid-bit check
      d_before = d_out;
      rxq.delete();
      rx = 1'b0;
      repeat (4) wait_tick();
      rx = 1'b1;
      repeat (4) wait_tick();
      chk("false start active", is_active, 1'b1);
      wait_tick();
      chk("false start aborted", is_active, 1'b0);
      repeat (10) wait_tick();
      chk("false start no done", rxq.size(), 0);
      chk("false start d_out kept", d_out, d_before);

      // Line stuck low: frame_err, then immediately a new START
      D_num = 1'b1; S_num = 1'b0; Par = P_NONE;
      rxq.delete();
      rx = 1'b0;
      waited = 0;
      while (rxq.size() == 0 && waited < OS * 14) begin
         wait_tick();
         waited++;
      end
      chk("stuck low done seen", rxq.size() > 0, 1'b1);
      rec = (rxq.size() > 0) ? rxq.pop_front() : 10'h3FF;
      chk("stuck low result", rec, {2'b10, 8'h00});
      repeat (2) wait_tick();
      chk("stuck low restart", is_active, 1'b1);
      hold(1'b1, OS * 14);

      // Reset during DATA bit 3
      run_frame('{8'h81, 1'b1, 1'b0, P_NONE, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0}, "pre-reset", 1'b0);
      rxq.delete();
      D_num = 1'b1; S_num = 1'b0; Par = P_NONE;
      hold(1'b0, OS);
      for (int i = 0; i < 3; i++) hold(v.data[0] ^ v.data[0] ^ ((8'h3C >> i) & 1), OS);
      hold(1'b1, 8);                       // into bit 3 of 8'h3C
      chk("mid-frame active", is_active, 1'b1);
      rst = 1'b0;
      #1;
      chk("rst is_active", is_active, 1'b0);
      chk("rst d_out", d_out, 8'h00);
      chk("rst flags", {rx_done, parity_err, frame_err}, 3'b000);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      hold(1'b1, OS * 4);
      chk("rst no done", rxq.size(), 0);
      run_frame('{8'h3C, 1'b1, 1'b0, P_NONE, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0}, "post-reset", 1'b0);

      chk("rx_done one clk wide", dbl_pulse, 0);
      chk("idle at rx_done", active_at_done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
